// File: rtl/add_sub_serial.sv
// Bit-serial adder/subtractor: DIGIT bits per cycle over WIDTH-bit operands,
// with carry-out, signed overflow and a valid/ack result handshake.
module add_sub_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             out_valid,
    input  logic             ack,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             load_c;
    logic [DIGIT:0]   dsum_c;

    // One digit of the ripple sum; bit DIGIT is the carry into the next digit.
    always_comb begin
        dsum_c = (DIGIT+1)'(a_q[DIGIT-1:0]) + (DIGIT+1)'(b_q[DIGIT-1:0])
               + (DIGIT+1)'(carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        count_d = count_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_c = 1'b1;
                end
            end
            S_ADD: begin
                out_d   = (out_q >> DIGIT) | (WIDTH'(dsum_c[DIGIT-1:0]) << (WIDTH - DIGIT));
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum_c[DIGIT];
                if (count_q == CNT_W'(N - 1)) begin
                    // Low digit now holds the operand MSBs; b is already inverted for sub.
                    cout_d  = dsum_c[DIGIT];
                    ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dsum_c[DIGIT-1] != a_q[DIGIT-1]);
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (ack) begin
                    if (start) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Operand load shared by IDLE start and back-to-back restart from DONE.
        if (load_c) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            count_d = '0;
            out_d   = '0;
            state_d = S_ADD;
        end
    end

    always_comb begin
        busy_d  = (state_d == S_ADD);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            count_q <= count_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out       = out_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: 8-bit instances with DIGIT=1 and DIGIT=4 checked
// against an integer-arithmetic reference model.
module tb_add_sub_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic       ack;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;

    logic       busy1, valid1, cout1, ovf1;
    logic [7:0] out1;
    logic       busy4, valid4, cout4, ovf4;
    logic [7:0] out4;

    logic       start1, start4, ack1, ack4;
    logic       busy_m, valid_m, cout_m, ovf_m;
    logic [7:0] out_m;

    int checks;
    int errors;

    logic [7:0] exp_out;
    logic       exp_cout;
    logic       exp_ovf;

    assign start1 = start & ~sel;
    assign start4 = start & sel;
    assign ack1   = ack & ~sel;
    assign ack4   = ack & sel;

    always_comb begin
        busy_m  = sel ? busy4  : busy1;
        valid_m = sel ? valid4 : valid1;
        out_m   = sel ? out4   : out1;
        cout_m  = sel ? cout4  : cout1;
        ovf_m   = sel ? ovf4   : ovf1;
    end

    add_sub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b),
        .busy(busy1), .out_valid(valid1), .ack(ack1), .out(out1),
        .cout(cout1), .ovf(ovf1)
    );

    add_sub_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a), .b(b),
        .busy(busy4), .out_valid(valid4), .ack(ack4), .out(out4),
        .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        int sa;
        int sb;
        int sr;
        int ua;
        int ub;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        ua = int'(av);
        ub = int'(bv);
        sr = sv ? (sa - sb) : (sa + sb);
        exp_ovf  = (sr < -128) || (sr > 127);
        exp_cout = sv ? (ua >= ub) : ((ua + ub) > 255);
        exp_out  = sv ? (av - bv) : (av + bv);
    endtask

    // Waits for out_valid counting busy cycles, then checks the result.
    task automatic wait_result(input int nb0, input bit pulse, input string tag);
        int nb;
        int cyc;
        nb  = nb0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            sub   = 1'($urandom_range(0, 1));
            if (busy_m) nb++;
            if (valid_m) break;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 40) check({tag, " timeout"}, 32'(valid_m), 32'd1);
        check({tag, " busy cycles"}, 32'(nb), sel ? 32'd2 : 32'd8);
        check({tag, " out"}, 32'(out_m), 32'(exp_out));
        check({tag, " cout"}, 32'(cout_m), 32'(exp_cout));
        check({tag, " ovf"}, 32'(ovf_m), 32'(exp_ovf));
    endtask

    task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input bit pulse, input string tag);
        @(negedge clk);
        sel   = s;
        a     = av;
        b     = bv;
        sub   = sv;
        start = 1'b1;
        model(av, bv, sv);
        wait_result(0, pulse, tag);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, " ack valid"}, 32'(valid_m), 32'd0);
        check({tag, " idle out held"}, 32'(out_m), 32'(exp_out));
    endtask

    task automatic b2b(input logic [7:0] av, input logic [7:0] bv, input logic sv, input string tag);
        @(negedge clk);
        a     = av;
        b     = bv;
        sub   = sv;
        start = 1'b1;
        ack   = 1'b1;
        model(av, bv, sv);
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
        check({tag, " b2b busy"}, 32'(busy_m), 32'd1);
        check({tag, " b2b valid"}, 32'(valid_m), 32'd0);
        if (!sel) check({tag, " b2b out cleared"}, 32'(out_m), 32'd0);
        wait_result(1, 1'b0, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        ack    = 1'b0;
        sub    = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        sel    = 1'b0;

        #1;
        check("reset out1", 32'(out1), 32'd0);
        check("reset flags1", {28'd0, busy1, valid1, cout1, ovf1}, 32'd0);
        check("reset out4", 32'(out4), 32'd0);
        check("reset flags4", {28'd0, busy4, valid4, cout4, ovf4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, "d1 5A+3C");
        do_ack("d1 5A+3C");
        run_op(1'b0, 8'h10, 8'h20, 1'b1, 1'b0, "d1 10-20");
        do_ack("d1 10-20");
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "d1 FF+01");
        do_ack("d1 FF+01");
        run_op(1'b1, 8'h80, 8'h01, 1'b1, 1'b0, "d4 80-01");
        do_ack("d4 80-01");

        // Back-to-back restart from DONE, on both digit sizes.
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, "d1 7F+01");
        b2b(8'h01, 8'h01, 1'b0, "d1 01+01");
        do_ack("d1 01+01");
        run_op(1'b1, 8'h00, 8'h01, 1'b1, 1'b0, "d4 00-01");
        b2b(8'h01, 8'h01, 1'b0, "d4 01+01");
        do_ack("d4 01+01");

        // DONE held without ack; start alone must not restart.
        run_op(1'b0, 8'hC3, 8'h5E, 1'b1, 1'b0, "d1 hold");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'(i % 2);
            check("hold valid", 32'(valid_m), 32'd1);
            check("hold out", 32'(out_m), 32'(exp_out));
        end
        start = 1'b0;
        do_ack("d1 hold");

        // Start pulses during ADD are ignored.
        run_op(1'b0, 8'h9C, 8'h47, 1'b0, 1'b1, "d1 pulse");
        do_ack("d1 pulse");
        run_op(1'b1, 8'h64, 8'hB2, 1'b1, 1'b1, "d4 pulse");
        do_ack("d4 pulse");

        // Asynchronous reset in the middle of an operation.
        run_op(1'b0, 8'h80, 8'h80, 1'b0, 1'b0, "d1 80+80");
        do_ack("d1 80+80");
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'h00;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset partial out", 32'(out_m), 32'hE0);
        rst_n = 1'b0;
        #1;
        check("mid reset out", 32'(out_m), 32'd0);
        check("mid reset flags", {28'd0, busy_m, valid_m, cout_m, ovf_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'h33, 8'h44, 1'b1, 1'b0, "d1 after reset");
        do_ack("d1 after reset");

        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 2) == 0) begin
                b2b(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand b2b");
            end
            do_ack("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
